freq_div_prog: RTL and testbench
================================

Name: freq_div_prog

Overview:
- Runtime-programmable successor to the fixed power-of-two divider.
- Divides clock_in by any integer N from 2 to 2^WIDTH-1 and produces a registered, near-50% duty clock_out plus a one-cycle tick strobe per period.
- The divisor is reloaded through a shadow register and handshake, and switches glitch-free only at period boundaries.
- Feeds FSM clock-enable and slow-clock domains on the board.

Parameters:
- WIDTH, 20, width of the divisor, the counter and the optional high-time value.
- DEFAULT_DIV, 4, divisor active after reset. Must be >= 2 and < 2^WIDTH; elaboration fails otherwise.

Ports:
- clock_in  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  count enable; when low, all counting is frozen.
- div_value  input  WIDTH  requested divisor N.
- div_load  input  1  one-cycle request to capture div_value.
- div_pending  output  1  a captured divisor is waiting for a period boundary.
- div_ack  output  1  one-cycle pulse; the new divisor took effect this cycle.
- div_err  output  1  one-cycle pulse; the requested divisor was rejected.
- clock_out  output  1  divided clock, registered.
- tick  output  1  one-cycle strobe, coincident with each rising edge of clock_out.

Behaviour:
- Reset (synchronous, highest priority):
  - active N = DEFAULT_DIV; count = DEFAULT_DIV-1; shadow cleared; div_pending = 0.
  - clock_out, tick, div_ack and div_err all 0.
  - Any pending load is discarded.
- High time: H = ceil(N/2), i.e. N - floor(N/2).
- Enabled edge:
  - count_next = (count == N-1) ? 0 : count+1.
  - clock_out <= (count_next < H).
  - tick <= (count_next == 0).
- Resulting pattern and timing:
  - Period is exactly N enabled cycles; clock_out is high for H cycles, then low for N-H.
  - Examples: N=5 gives 11100; N=4 gives 1100.
  - The first enabled edge after reset release produces a rising edge on clock_out and a tick.
- Enable low:
  - count, clock_out and active N hold.
  - tick is 0.
  - Load capture still operates; a pending load waits until the next enabled wrap.
- Load request (div_load=1):
  - If 2 <= div_value: shadow <= div_value and div_pending <= 1 on the next edge.
  - If div_value < 2: shadow is unchanged, div_err = 1 on the next edge (one cycle), and div_pending is unaffected.
- Multiple loads before a boundary: the last valid value wins; exactly one div_ack is issued.
- Apply: on an enabled edge with count_next == 0 and div_pending = 1, and no div_load in the same cycle:
  - active N <= shadow; count <= 0; clock_out <= 1; tick <= 1; div_ack <= 1; div_pending <= 0.
  - The new period starts with the new N and its new H. The old period always completes in full.
- Load on the same edge as a wrap: the value is captured into the shadow but applied at the following wrap, not the current one.
- No combinational path from any input to any output.

Optional Feature:
- Macro: FREQ_DIV_DUTY_EN.
- When defined:
  - Adds input high_value [WIDTH], captured together with div_value on div_load.
  - H = high_value.
  - The load is valid only if N >= 2 and 1 <= high_value <= N-1; otherwise div_err pulses and nothing is captured.
  - Reset H = DEFAULT_DIV/2 (integer division).
- When not defined: the high_value port is absent and H = ceil(N/2) as above.

Test Plan:
- DEFAULT_DIV=4, reset 3 cycles, then enable=1 -> clock_out 1100 repeating; tick on cycles 1, 5, 9 after release; div_ack and div_err never pulse.
- Load 5 at count=1 -> div_pending=1 on the next cycle; the 1100 period finishes; then 11100 repeating; div_ack coincident with the first tick of the new period; div_pending back to 0.
- Load 1, then load 0 -> a div_err pulse one cycle after each; no div_ack; 1100 continues unchanged.
- enable=0 for 3 cycles during the high phase -> clock_out held at 1; no tick; that period stretched to 7 clock_in cycles; pattern unchanged afterwards.
- Load 6, then load 3 two cycles later, both before the wrap -> a single div_ack; pattern becomes 110.
- Load 7 then reset mid-period -> clock_out=0, div_pending=0; after release N=4 (1100) with no div_ack.

Source files
------------

// File: rtl/freq_div_prog.sv
`default_nettype none
// ============================================================================
// Module   : freq_div_prog
// Brief    : Runtime-programmable integer clock divider (N = 2 .. 2^WIDTH-1)
//            with a registered near-50% clock_out, a period tick, and a
//            shadowed divisor reload that switches only at period boundaries.
//            Optional macro FREQ_DIV_DUTY_EN adds a programmable high time.
// Revision : 1.0 - initial release
// ============================================================================
module freq_div_prog #(
    parameter int WIDTH       = 20,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] div_value,
`ifdef FREQ_DIV_DUTY_EN
    input  logic [WIDTH-1:0] high_value,
`endif
    input  logic             div_load,
    output logic             div_pending,
    output logic             div_ack,
    output logic             div_err,
    output logic             clock_out,
    output logic             tick
);

    localparam logic [WIDTH-1:0] c_one     = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_two     = WIDTH'(2);
    localparam logic [WIDTH-1:0] c_def_div = WIDTH'(DEFAULT_DIV);

    if (DEFAULT_DIV < 2 || longint'(DEFAULT_DIV) >= (longint'(1) << WIDTH)) begin : g_bad_default
        $error("freq_div_prog: DEFAULT_DIV must be >= 2 and < 2**WIDTH");
    end

    logic [WIDTH-1:0] n_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] shadow_q;
    logic [WIDTH-1:0] h_act;
    logic             pend_q;
    logic             clk_q;
    logic             tick_q;
    logic             ack_q;
    logic             err_q;
    logic             wrap;
    logic             load_ok;
    logic             apply;

`ifdef FREQ_DIV_DUTY_EN
    logic [WIDTH-1:0] h_q;
    logic [WIDTH-1:0] shadow_h_q;

    assign h_act   = h_q;
    assign load_ok = (div_value >= c_two) && (high_value >= c_one)
                     && (high_value <= div_value - c_one);
`else
    // High time is ceil(N/2), giving the extra cycle to the high phase for odd N.
    assign h_act   = n_q - (n_q >> 1);
    assign load_ok = (div_value >= c_two);
`endif

    assign wrap  = (cnt_q == n_q - c_one);
    assign cnt_d = wrap ? '0 : cnt_q + c_one;
    // A load landing on the wrap edge defers the switch to the following wrap.
    assign apply = enable && wrap && pend_q && !div_load;

    always_ff @(posedge clock_in) begin
        if (reset) begin
            n_q        <= c_def_div;
            cnt_q      <= c_def_div - c_one;
            shadow_q   <= '0;
            pend_q     <= 1'b0;
            clk_q      <= 1'b0;
            tick_q     <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
`ifdef FREQ_DIV_DUTY_EN
            h_q        <= c_def_div >> 1;
            shadow_h_q <= '0;
`endif
        end else begin
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            tick_q <= 1'b0;

            if (div_load) begin
                if (load_ok) begin
                    shadow_q   <= div_value;
                    pend_q     <= 1'b1;
`ifdef FREQ_DIV_DUTY_EN
                    shadow_h_q <= high_value;
`endif
                end else begin
                    err_q <= 1'b1;
                end
            end

            if (apply) begin
                n_q    <= shadow_q;
                cnt_q  <= '0;
                clk_q  <= 1'b1;
                tick_q <= 1'b1;
                ack_q  <= 1'b1;
                pend_q <= 1'b0;
`ifdef FREQ_DIV_DUTY_EN
                h_q    <= shadow_h_q;
`endif
            end else if (enable) begin
                cnt_q  <= cnt_d;
                clk_q  <= (cnt_d < h_act);
                tick_q <= (cnt_d == '0);
            end
        end
    end

    assign div_pending = pend_q;
    assign div_ack     = ack_q;
    assign div_err     = err_q;
    assign clock_out   = clk_q;
    assign tick        = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_freq_div_prog.sv
`default_nettype none
// ============================================================================
// Module   : tb_freq_div_prog
// Brief    : Self-checking bench for freq_div_prog (default build, N0 = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_freq_div_prog;

    localparam int W = 20;

    logic         clock_in = 1'b0;
    logic         reset;
    logic         enable;
    logic         div_load;
    logic [W-1:0] div_value;
    logic         div_pending;
    logic         div_ack;
    logic         div_err;
    logic         clock_out;
    logic         tick;

    int checks = 0;
    int errors = 0;

    always #5 clock_in = ~clock_in;

    freq_div_prog #(.WIDTH(W), .DEFAULT_DIV(4)) dut (
        .clock_in    (clock_in),
        .reset       (reset),
        .enable      (enable),
        .div_value   (div_value),
        .div_load    (div_load),
        .div_pending (div_pending),
        .div_ack     (div_ack),
        .div_err     (div_err),
        .clock_out   (clock_out),
        .tick        (tick)
    );

    // Reference model: position within the current period plus the reload queue.
    int   m_n, m_pos, m_shadow;
    logic m_pend, m_clk, m_tick, m_ack, m_err;

    function automatic void model_reset();
        m_n = 4; m_pos = 3; m_shadow = 0;
        m_pend = 1'b0; m_clk = 1'b0; m_tick = 1'b0; m_ack = 1'b0; m_err = 1'b0;
    endfunction

    function automatic void model_step(input logic en, input logic ld, input int val);
        m_ack = 1'b0; m_err = 1'b0; m_tick = 1'b0;
        if (en) begin
            m_pos = (m_pos + 1) % m_n;
            if (m_pos == 0) begin
                m_tick = 1'b1;
                if (m_pend && !ld) begin
                    m_n = m_shadow; m_pend = 1'b0; m_ack = 1'b1;
                end
            end
            m_clk = (m_pos < (m_n + 1) / 2);
        end
        if (ld) begin
            if (val >= 2) begin m_shadow = val; m_pend = 1'b1; end
            else m_err = 1'b1;
        end
    endfunction

    function automatic logic [4:0] act_vec();
        return {clock_out, tick, div_pending, div_ack, div_err};
    endfunction

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: clk/tick/pend/ack/err got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock_in cycle; optionally compares against the model afterwards.
    task automatic step(input logic rst, input logic en, input logic ld, input int val,
                        input bit chk, input string name);
        reset = rst; enable = en; div_load = ld; div_value = W'(val);
        @(posedge clock_in); #1;
        if (rst) model_reset();
        else     model_step(en, ld, val);
        if (chk) check(name, act_vec(), {m_clk, m_tick, m_pend, m_ack, m_err});
    endtask

    task automatic do_reset(input bit chk);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 0, chk, "reset");
    endtask

    typedef struct {
        logic       en;
        logic       ld;
        int         val;
        logic [4:0] exp;   // {clock_out, tick, div_pending, div_ack, div_err}
    } vec_t;

    vec_t tbl[30];

    initial begin
        int t0, len, acks;

        tbl[0]  = '{1'b1, 1'b0, 0, 5'b11000};
        tbl[1]  = '{1'b1, 1'b0, 0, 5'b10000};
        tbl[2]  = '{1'b1, 1'b1, 5, 5'b00100};
        tbl[3]  = '{1'b1, 1'b0, 0, 5'b00100};
        tbl[4]  = '{1'b1, 1'b0, 0, 5'b11010};
        tbl[5]  = '{1'b1, 1'b0, 0, 5'b10000};
        tbl[6]  = '{1'b1, 1'b0, 0, 5'b10000};
        tbl[7]  = '{1'b1, 1'b0, 0, 5'b00000};
        tbl[8]  = '{1'b1, 1'b0, 0, 5'b00000};
        tbl[9]  = '{1'b1, 1'b0, 0, 5'b11000};
        tbl[10] = '{1'b1, 1'b1, 1, 5'b10001};
        tbl[11] = '{1'b1, 1'b1, 0, 5'b10001};
        tbl[12] = '{1'b1, 1'b0, 0, 5'b00000};
        tbl[13] = '{1'b1, 1'b0, 0, 5'b00000};
        tbl[14] = '{1'b1, 1'b0, 0, 5'b11000};
        tbl[15] = '{1'b0, 1'b0, 0, 5'b10000};
        tbl[16] = '{1'b0, 1'b1, 4, 5'b10100};
        tbl[17] = '{1'b1, 1'b0, 0, 5'b10100};
        tbl[18] = '{1'b1, 1'b0, 0, 5'b10100};
        tbl[19] = '{1'b1, 1'b0, 0, 5'b00100};
        tbl[20] = '{1'b1, 1'b0, 0, 5'b00100};
        tbl[21] = '{1'b1, 1'b0, 0, 5'b11010};
        tbl[22] = '{1'b1, 1'b0, 0, 5'b10000};
        tbl[23] = '{1'b1, 1'b0, 0, 5'b00000};
        tbl[24] = '{1'b1, 1'b0, 0, 5'b00000};
        tbl[25] = '{1'b1, 1'b1, 6, 5'b11100};
        tbl[26] = '{1'b1, 1'b0, 0, 5'b10100};
        tbl[27] = '{1'b1, 1'b0, 0, 5'b00100};
        tbl[28] = '{1'b1, 1'b0, 0, 5'b00100};
        tbl[29] = '{1'b1, 1'b0, 0, 5'b11010};

        reset = 1'b1; enable = 1'b0; div_load = 1'b0; div_value = '0;
        model_reset();

        // Directed table: reset state, 1100, reload to 5, rejects, freeze, load-at-wrap.
        do_reset(1'b0);
        check("reset_state", act_vec(), 5'b00000);
        for (int i = 0; i < 30; i++) begin
            step(1'b0, tbl[i].en, tbl[i].ld, tbl[i].val, 1'b0, "");
            check($sformatf("table_row%0d", i), act_vec(), tbl[i].exp);
        end

        // Enable held low for 3 cycles in the high phase stretches the period to 7.
        do_reset(1'b1);
        step(1'b0, 1'b1, 1'b0, 0, 1'b1, "stretch_first");
        len = 0;
        t0 = 0;
        step(1'b0, 1'b1, 1'b0, 0, 1'b1, "stretch_run");
        len++;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 0, 1'b1, "stretch_hold");
            len++;
        end
        while (!tick && t0 < 20) begin
            step(1'b0, 1'b1, 1'b0, 0, 1'b1, "stretch_run");
            len++;
            t0++;
        end
        check_int("stretch_period", len, 7);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 0, 1'b1, "stretch_after");

        // Two loads before one wrap: last value wins, one ack only.
        do_reset(1'b1);
        step(1'b0, 1'b1, 1'b0, 0, 1'b1, "multi_first");
        step(1'b0, 1'b1, 1'b1, 6, 1'b1, "multi_ld6");
        step(1'b0, 1'b1, 1'b0, 0, 1'b1, "multi_gap");
        step(1'b0, 1'b1, 1'b1, 3, 1'b1, "multi_ld3");
        acks = 0;
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 1'b1, 1'b0, 0, 1'b1, "multi_run");
            if (div_ack) acks++;
        end
        check_int("multi_ack_count", acks, 1);

        // Reset mid-period discards a pending load.
        step(1'b0, 1'b1, 1'b1, 7, 1'b1, "rst_ld7");
        step(1'b0, 1'b1, 1'b0, 0, 1'b1, "rst_mid");
        step(1'b1, 1'b1, 1'b0, 0, 1'b0, "");
        check("rst_midperiod", act_vec(), 5'b00000);
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 1'b0, 0, 1'b1, "rst_after");
            if (div_ack) acks++;
        end
        check_int("rst_no_ack", acks, 0);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic r_rst, r_en, r_ld;
            int   r_val;
            r_rst = ($urandom_range(0, 199) == 0);
            r_en  = ($urandom_range(0, 3) != 0);
            r_ld  = ($urandom_range(0, 9) == 0);
            r_val = $urandom_range(0, 9);
            step(r_rst, r_en, r_ld, r_val, 1'b1, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
